// File: rtl/parallel_out_pkg.sv
// Shared types for the memory-mapped parallel output bank.
package parallel_out_pkg;

    localparam int unsigned OP_W        = 2;
    localparam int unsigned OPS_PER_CH  = 4;

    typedef enum logic [OP_W-1:0] {
        OP_WRITE = 2'b00,
        OP_SET   = 2'b01,
        OP_CLR   = 2'b10,
        OP_PULSE = 2'b11
    } pout_op_e;

    typedef enum logic {
        PO_IDLE    = 1'b0,
        PO_PULSING = 1'b1
    } pout_state_e;

    // Address bits spanned by the whole window (OPS_PER_CH slots per channel).
    function automatic int unsigned win_bits(input int unsigned n_ch);
        return $clog2(OPS_PER_CH * n_ch);
    endfunction

endpackage

// File: rtl/pout_channel.sv
// One output channel: data register, pulse mask, pulse timer and IDLE/PULSING FSM.
module pout_channel
    import parallel_out_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned PULSE_LEN = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    input  pout_op_e          op,
    input  logic [DATA_W-1:0] data,
    output logic [DATA_W-1:0] q,
    output logic              busy
);

    localparam int unsigned       CNT_W    = $clog2(PULSE_LEN + 1);
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(PULSE_LEN);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    pout_state_e       state_q, state_d;
    logic [DATA_W-1:0] q_d;
    logic [DATA_W-1:0] mask_q, mask_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              busy_d;
    logic              at_expiry;

    // Next-state: a command always wins over timer expiry in the same cycle.
    always_comb begin
        state_d   = state_q;
        q_d       = q;
        mask_d    = mask_q;
        cnt_d     = cnt_q;
        at_expiry = (state_q == PO_PULSING) && (cnt_q == CNT_ONE);

        if (cmd_valid) begin
            case (op)
                OP_WRITE: begin
                    q_d     = data;
                    mask_d  = '0;
                    cnt_d   = '0;
                    state_d = PO_IDLE;
                end
                OP_SET: begin
                    q_d    = q | data;
                    mask_d = mask_q & ~data;
                    // Timer keeps running; on the expiry cycle it holds so expiry lands next cycle.
                    if ((state_q == PO_PULSING) && !at_expiry) begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                OP_CLR: begin
                    q_d     = q & ~data;
                    mask_d  = '0;
                    cnt_d   = '0;
                    state_d = PO_IDLE;
                end
                OP_PULSE: begin
                    q_d     = q | data;
                    mask_d  = mask_q | data;
                    cnt_d   = CNT_LOAD;
                    state_d = PO_PULSING;
                end
                default: begin
                    q_d = q;
                end
            endcase
        end else if (state_q == PO_PULSING) begin
            if (at_expiry) begin
                q_d     = q & ~mask_q;
                mask_d  = '0;
                cnt_d   = '0;
                state_d = PO_IDLE;
            end else begin
                cnt_d = cnt_q - CNT_ONE;
            end
        end

        busy_d = (state_d == PO_PULSING);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= PO_IDLE;
            q       <= '0;
            mask_q  <= '0;
            cnt_q   <= '0;
            busy    <= 1'b0;
        end else begin
            state_q <= state_d;
            q       <= q_d;
            mask_q  <= mask_d;
            cnt_q   <= cnt_d;
            busy    <= busy_d;
        end
    end

endmodule

// File: rtl/parallel_out_bank.sv
// Address-window decode on the store bus feeding a bank of N_CH output channels.
module parallel_out_bank
    import parallel_out_pkg::*;
#(
    parameter int unsigned       DATA_W    = 8,
    parameter int unsigned       ADDR_W    = 8,
    parameter int unsigned       N_CH      = 4,
    parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(8'hF0),
    parameter int unsigned       PULSE_LEN = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   we,
    input  logic [ADDR_W-1:0]      Address,
    input  logic [DATA_W-1:0]      RegData,
    output logic [N_CH*DATA_W-1:0] DataOut,
    output logic                   wren,
    output logic                   hit,
    output logic [DATA_W-1:0]      rd_data,
    output logic [N_CH-1:0]        pulse_busy
);

    localparam int unsigned WIN_W = win_bits(N_CH);
    localparam int unsigned CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic [CH_W-1:0]   ch;
    pout_op_e          op;
    logic [DATA_W-1:0] ch_q [N_CH];

    // Window is aligned, so only the upper bits need to match the base.
    assign hit  = (Address[ADDR_W-1:WIN_W] == BASE_ADDR[ADDR_W-1:WIN_W]);
    assign wren = we & ~hit;
    assign op   = pout_op_e'(Address[OP_W-1:0]);

    generate
        if (N_CH > 1) begin : g_ch_sel
            assign ch = Address[CH_W+1:2];
        end else begin : g_ch_one
            assign ch = '0;
        end
    endgenerate

    always_comb begin
        rd_data = '0;
        for (int k = 0; k < int'(N_CH); k++) begin
            if (hit && (ch == CH_W'(k))) begin
                rd_data = ch_q[k];
            end
        end
    end

    generate
        for (genvar k = 0; k < int'(N_CH); k++) begin : g_ch
            logic cmd_valid;
            assign cmd_valid = we & hit & (ch == CH_W'(k));

            pout_channel #(
                .DATA_W    (DATA_W),
                .PULSE_LEN (PULSE_LEN)
            ) u_channel (
                .clk       (clk),
                .reset     (reset),
                .cmd_valid (cmd_valid),
                .op        (op),
                .data      (RegData),
                .q         (ch_q[k]),
                .busy      (pulse_busy[k])
            );

            assign DataOut[k*DATA_W +: DATA_W] = ch_q[k];
        end
    endgenerate

endmodule

// File: tb/tb_parallel_out_bank.sv
// Scoreboard bench for parallel_out_bank: expected post-edge state queued per cycle.
module tb_parallel_out_bank;

    logic        clk = 1'b0;
    logic        reset;
    logic        we;
    logic [7:0]  Address;
    logic [7:0]  RegData;
    logic [31:0] DataOut;
    logic        wren;
    logic        hit;
    logic [7:0]  rd_data;
    logic [3:0]  pulse_busy;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       tag;
        logic [31:0] dout;
        logic [3:0]  busy;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    parallel_out_bank #(
        .DATA_W    (8),
        .ADDR_W    (8),
        .N_CH      (4),
        .BASE_ADDR (8'hF0),
        .PULSE_LEN (3)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .we         (we),
        .Address    (Address),
        .RegData    (RegData),
        .DataOut    (DataOut),
        .wren       (wren),
        .hit        (hit),
        .rd_data    (rd_data),
        .pulse_busy (pulse_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic w, input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        we      = w;
        Address = a;
        RegData = d;
    endtask

    task automatic tick(input logic [31:0] dout, input logic [3:0] busy, input string tag);
        exp_t x;
        x.tag  = tag;
        x.dout = dout;
        x.busy = busy;
        sb.push_back(x);
        @(posedge clk);
    endtask

    task automatic cmd(input logic [7:0] a, input logic [7:0] d,
                       input logic [31:0] dout, input logic [3:0] busy, input string tag);
        drive(1'b1, a, d);
        tick(dout, busy, tag);
    endtask

    task automatic idle(input logic [31:0] dout, input logic [3:0] busy, input string tag);
        drive(1'b0, 8'h00, 8'h00);
        tick(dout, busy, tag);
    endtask

    // Compare DUT state one step after each edge against the queued expectation.
    always begin
        @(posedge clk);
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({e.tag, "_dout"}, DataOut, e.dout);
            chk({e.tag, "_busy"}, 32'(pulse_busy), 32'(e.busy));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset   = 1'b1;
        we      = 1'b0;
        Address = 8'h00;
        RegData = 8'h00;
        idle(32'h0000_0000, 4'h0, "rst0");
        idle(32'h0000_0000, 4'h0, "rst1");
        reset = 1'b0;

        // Plain write to ch1, combinational decode and readback
        drive(1'b1, 8'hF4, 8'hA5);
        #1;
        chk("t1_hit", 32'(hit), 32'd1);
        chk("t1_wren", 32'(wren), 32'd0);
        tick(32'h0000_A500, 4'h0, "t1_wr");
        drive(1'b0, 8'hF4, 8'h00);
        #1;
        chk("t1_rd", 32'(rd_data), 32'hA5);
        chk("t1_wren_idle", 32'(wren), 32'd0);
        tick(32'h0000_A500, 4'h0, "t1_idle");

        // Bit set then bit clear on ch1
        cmd(8'hF5, 8'h0F, 32'h0000_AF00, 4'h0, "t2_set");
        cmd(8'hF6, 8'hA0, 32'h0000_0F00, 4'h0, "t2_clr");

        // Single pulse on ch2: high for exactly 3 cycles
        cmd(8'hFB, 8'h81, 32'h0081_0F00, 4'h4, "t3_p0");
        idle(32'h0081_0F00, 4'h4, "t3_p1");
        idle(32'h0081_0F00, 4'h4, "t3_p2");
        idle(32'h0000_0F00, 4'h0, "t3_end");
        idle(32'h0000_0F00, 4'h0, "t3_hold");

        // Overlapping pulses, SET makes bit0 permanent, bit1 expires
        cmd(8'hFB, 8'h01, 32'h0001_0F00, 4'h4, "t4_p1");
        cmd(8'hFB, 8'h02, 32'h0003_0F00, 4'h4, "t4_p2");
        cmd(8'hF9, 8'h01, 32'h0003_0F00, 4'h4, "t4_set");
        idle(32'h0003_0F00, 4'h4, "t4_run");
        idle(32'h0001_0F00, 4'h0, "t4_exp");
        idle(32'h0001_0F00, 4'h0, "t4_hold");

        // WRITE mid-pulse cancels the pending clear
        cmd(8'hFB, 8'h10, 32'h0011_0F00, 4'h4, "t4_pw");
        cmd(8'hF8, 8'h40, 32'h0040_0F00, 4'h0, "t4_wr");
        idle(32'h0040_0F00, 4'h0, "t4_w1");
        idle(32'h0040_0F00, 4'h0, "t4_w2");
        idle(32'h0040_0F00, 4'h0, "t4_w3");

        // Out-of-window store goes to memory only
        drive(1'b1, 8'h10, 8'hFF);
        #1;
        chk("t5_wren", 32'(wren), 32'd1);
        chk("t5_hit", 32'(hit), 32'd0);
        chk("t5_rd", 32'(rd_data), 32'h00);
        tick(32'h0040_0F00, 4'h0, "t5_oow");
        drive(1'b1, 8'hEF, 8'hFF);
        #1;
        chk("t5_below_hit", 32'(hit), 32'd0);
        tick(32'h0040_0F00, 4'h0, "t5_below");
        drive(1'b0, 8'hF4, 8'h00);
        #1;
        chk("t5_wren_we0", 32'(wren), 32'd0);
        chk("t5_rd_ch1", 32'(rd_data), 32'h0F);
        tick(32'h0040_0F00, 4'h0, "t5_we0");

        // PULSE with zero data still runs the timer
        cmd(8'hFF, 8'h00, 32'h0040_0F00, 4'h8, "bz_p");
        idle(32'h0040_0F00, 4'h8, "bz_1");
        idle(32'h0040_0F00, 4'h8, "bz_2");
        idle(32'h0040_0F00, 4'h0, "bz_end");

        // CLR coincident with expiry cancels the pulse
        cmd(8'hF3, 8'h0C, 32'h0040_0F0C, 4'h1, "bc_p");
        idle(32'h0040_0F0C, 4'h1, "bc_1");
        idle(32'h0040_0F0C, 4'h1, "bc_2");
        cmd(8'hF2, 8'h04, 32'h0040_0F08, 4'h0, "bc_clr");
        idle(32'h0040_0F08, 4'h0, "bc_h1");
        idle(32'h0040_0F08, 4'h0, "bc_h2");

        // SET coincident with expiry defers expiry by one cycle
        cmd(8'hF3, 8'h30, 32'h0040_0F38, 4'h1, "bs_p");
        idle(32'h0040_0F38, 4'h1, "bs_1");
        idle(32'h0040_0F38, 4'h1, "bs_2");
        cmd(8'hF1, 8'h10, 32'h0040_0F38, 4'h1, "bs_set");
        idle(32'h0040_0F18, 4'h0, "bs_exp");
        idle(32'h0040_0F18, 4'h0, "bs_hold");

        // Reset aborts a pulse and overrides a coincident store
        cmd(8'hFF, 8'hFF, 32'hFF40_0F18, 4'h8, "t6_p");
        drive(1'b1, 8'hF4, 8'h55);
        reset = 1'b1;
        tick(32'h0000_0000, 4'h0, "t6_rst");
        drive(1'b1, 8'hFD, 8'hF0);
        reset = 1'b0;
        tick(32'hF000_0000, 4'h0, "t6_set");
        idle(32'hF000_0000, 4'h0, "t6_h1");
        idle(32'hF000_0000, 4'h0, "t6_h2");
        idle(32'hF000_0000, 4'h0, "t6_h3");

        @(negedge clk);
        chk("sb_drain", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
